// File: rtl/lcd_window_seq.sv
// Window-update sequencer for the 8-bit LCD serializer.
// Emits 2A/2B/2C address commands, then streams RGB565 pixels high byte first.
module lcd_window_seq #(
   parameter int WIDTH  = 320,
   parameter int HEIGHT = 240,
   localparam int XW = $clog2(WIDTH),
   localparam int YW = $clog2(HEIGHT)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          win_req,
   input  logic [XW-1:0] x0,
   input  logic [XW-1:0] x1,
   input  logic [YW-1:0] y0,
   input  logic [YW-1:0] y1,
   input  logic          pix_valid,
   output logic          pix_ready,
   input  logic [15:0]   color,
   output logic          byte_valid,
   input  logic          byte_ready,
   output logic [7:0]    dataout,
   output logic          rs,
   output logic [XW-1:0] hpos,
   output logic [YW-1:0] vpos,
   output logic          busy,
   output logic          done,
   output logic          err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_FETCH,
      S_HI,
      S_LO,
      S_DONE
   } state_t;

   localparam logic [XW:0] XLIM = (XW+1)'(WIDTH);
   localparam logic [YW:0] YLIM = (YW+1)'(HEIGHT);

   state_t        state_q, state_d;
   logic [3:0]    idx_q, idx_d;
   logic [XW-1:0] x0_q, x0_d;
   logic [XW-1:0] x1_q, x1_d;
   logic [YW-1:0] y0_q, y0_d;
   logic [YW-1:0] y1_q, y1_d;
   logic [XW-1:0] hpos_q, hpos_d;
   logic [YW-1:0] vpos_q, vpos_d;
   logic [15:0]   color_q, color_d;
   logic          bv_q, bv_d;
   logic [7:0]    dout_q, dout_d;
   logic          rs_q, rs_d;
   logic          err_q, err_d;

   logic win_ok;
   logic xfer;
   logic last_pix;
   logic [8:0] cmd_next;

   // Command byte for a given index, as {rs, byte}.
   function automatic logic [8:0] cmd_byte(
      input logic [3:0]  i,
      input logic [15:0] a,
      input logic [15:0] b,
      input logic [15:0] c,
      input logic [15:0] d
   );
      unique case (i)
         4'd0:    return {1'b0, 8'h2A};
         4'd1:    return {1'b1, a[15:8]};
         4'd2:    return {1'b1, a[7:0]};
         4'd3:    return {1'b1, b[15:8]};
         4'd4:    return {1'b1, b[7:0]};
         4'd5:    return {1'b0, 8'h2B};
         4'd6:    return {1'b1, c[15:8]};
         4'd7:    return {1'b1, c[7:0]};
         4'd8:    return {1'b1, d[15:8]};
         4'd9:    return {1'b1, d[7:0]};
         default: return {1'b0, 8'h2C};
      endcase
   endfunction

   assign win_ok = (x0 <= x1) && ({1'b0, x1} < XLIM)
                && (y0 <= y1) && ({1'b0, y1} < YLIM);
   assign xfer     = bv_q && byte_ready;
   assign last_pix = (hpos_q == x1_q) && (vpos_q == y1_q);
   assign cmd_next = cmd_byte(idx_q + 4'd1,
                              16'(x0_q), 16'(x1_q),
                              16'(y0_q), 16'(y1_q));

   // Next-state, position and output-byte computation.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      x0_d    = x0_q;
      x1_d    = x1_q;
      y0_d    = y0_q;
      y1_d    = y1_q;
      hpos_d  = hpos_q;
      vpos_d  = vpos_q;
      color_d = color_q;
      bv_d    = bv_q;
      dout_d  = dout_q;
      rs_d    = rs_q;
      err_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (win_req) begin
               if (win_ok) begin
                  x0_d    = x0;
                  x1_d    = x1;
                  y0_d    = y0;
                  y1_d    = y1;
                  hpos_d  = x0;
                  vpos_d  = y0;
                  idx_d   = 4'd0;
                  state_d = S_CMD;
                  bv_d    = 1'b1;
                  dout_d  = 8'h2A;
                  rs_d    = 1'b0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_CMD: begin
            if (xfer) begin
               if (idx_q == 4'd10) begin
                  state_d = S_FETCH;
                  bv_d    = 1'b0;
               end else begin
                  idx_d  = idx_q + 4'd1;
                  rs_d   = cmd_next[8];
                  dout_d = cmd_next[7:0];
               end
            end
         end
         S_FETCH: begin
            if (pix_valid) begin
               color_d = color;
               state_d = S_HI;
               bv_d    = 1'b1;
               rs_d    = 1'b1;
               dout_d  = color[15:8];
            end
         end
         S_HI: begin
            if (xfer) begin
               state_d = S_LO;
               dout_d  = color_q[7:0];
            end
         end
         S_LO: begin
            if (xfer) begin
               bv_d = 1'b0;
               if (last_pix) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_FETCH;
                  if (hpos_q == x1_q) begin
                     hpos_d = x0_q;
                     vpos_d = vpos_q + 1'b1;
                  end else begin
                     hpos_d = hpos_q + 1'b1;
                  end
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            bv_d    = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset abandons any transfer at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         x0_q    <= '0;
         x1_q    <= '0;
         y0_q    <= '0;
         y1_q    <= '0;
         hpos_q  <= '0;
         vpos_q  <= '0;
         color_q <= '0;
         bv_q    <= 1'b0;
         dout_q  <= '0;
         rs_q    <= 1'b1;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         x0_q    <= x0_d;
         x1_q    <= x1_d;
         y0_q    <= y0_d;
         y1_q    <= y1_d;
         hpos_q  <= hpos_d;
         vpos_q  <= vpos_d;
         color_q <= color_d;
         bv_q    <= bv_d;
         dout_q  <= dout_d;
         rs_q    <= rs_d;
         err_q   <= err_d;
      end
   end

   assign byte_valid = bv_q;
   assign dataout    = dout_q;
   assign rs         = rs_q;
   assign hpos       = hpos_q;
   assign vpos       = vpos_q;
   assign err        = err_q;
   assign pix_ready  = (state_q == S_FETCH);
   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_lcd_window_seq.sv
// Bench for lcd_window_seq: random pixels and handshakes
// checked against a queue model of the expected byte stream.
module tb_lcd_window_seq;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       win_req = 1'b0;
   logic [8:0] x0 = '0;
   logic [8:0] x1 = '0;
   logic [7:0] y0 = '0;
   logic [7:0] y1 = '0;
   logic       pix_valid = 1'b0;
   logic       pix_ready;
   logic [15:0] color = '0;
   logic       byte_valid;
   logic       byte_ready = 1'b0;
   logic [7:0] dataout;
   logic       rs;
   logic [8:0] hpos;
   logic [7:0] vpos;
   logic       busy;
   logic       done;
   logic       err;

   int errs = 0;
   int checks = 0;

   typedef struct {
      logic       rs;
      logic [7:0] b;
      bit         pix;
      int         h;
      int         v;
   } exp_t;

   lcd_window_seq dut (
      .clk(clk), .reset(reset), .win_req(win_req),
      .x0(x0), .x1(x1), .y0(y0), .y1(y1),
      .pix_valid(pix_valid), .pix_ready(pix_ready),
      .color(color), .byte_valid(byte_valid),
      .byte_ready(byte_ready), .dataout(dataout),
      .rs(rs), .hpos(hpos), .vpos(vpos),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk_reset_vals(input string nm);
      logic [31:0] got, want;
      got  = {byte_valid, pix_ready, dataout, rs,
              hpos, vpos, busy, done, err};
      want = {1'b0, 1'b0, 8'h00, 1'b1,
              9'd0, 8'd0, 1'b0, 1'b0, 1'b0};
      checks++;
      if (got !== want) begin
         errs++;
         $display("FAIL %s: outputs got %h want %h", nm, got, want);
      end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset_vals("reset_state");
      reset = 1'b1;
      @(negedge clk);
      chk_reset_vals("idle_after_reset");
   endtask

   task automatic run_window(
      input int ax0, input int ax1,
      input int ay0, input int ay1,
      input int mode, input int abort,
      input bit poke, input int fixc,
      output int nb
   );
      exp_t q[$];
      logic [15:0] cols[$];
      exp_t e;
      int pi, pb, cyc, sc, budget, npix;
      bit fin, stalled, br;
      logic [7:0] pd;
      logic prs;
      logic [16:0] bg, bw;
      logic [25:0] tg, tw;
      logic [15:0] cv;
      int crd[4];
      crd[0] = ax0; crd[1] = ax1; crd[2] = ay0; crd[3] = ay1;
      for (int k = 0; k < 4; k++) begin
         e.rs = 1'b0; e.pix = 0; e.h = 0; e.v = 0;
         e.b = (k == 0) ? 8'h2A : (k == 2) ? 8'h2B : 8'h00;
         if (k == 0 || k == 2) q.push_back(e);
         e.rs = 1'b1;
         e.b = 8'((crd[k] / 256) % 256);
         q.push_back(e);
         e.b = 8'(crd[k] % 256);
         q.push_back(e);
      end
      e.rs = 1'b0; e.b = 8'h2C;
      q.push_back(e);
      for (int yy = ay0; yy <= ay1; yy++)
         for (int xx = ax0; xx <= ax1; xx++) begin
            cv = (fixc >= 0) ? 16'(fixc) : 16'($urandom);
            cols.push_back(cv);
            e.rs = 1'b1; e.pix = 1; e.h = xx; e.v = yy;
            e.b = cv[15:8];
            q.push_back(e);
            e.b = cv[7:0];
            q.push_back(e);
         end
      npix = cols.size();
      budget = 200 + npix * 20;
      pi = 0; pb = 0; cyc = 0; sc = 0; nb = 0;
      fin = 0; stalled = 0; br = 1'b1;
      pd = '0; prs = 1'b0;
      @(negedge clk);
      x0 = 9'(ax0); x1 = 9'(ax1);
      y0 = 8'(ay0); y1 = 8'(ay1);
      win_req = 1'b1;
      @(negedge clk);
      while (!fin && cyc < budget) begin
         cyc++;
         checks++;
         if (err !== 1'b0 || busy !== 1'b1) begin
            errs++;
            $display("FAIL run_flags: err=%b busy=%b want 0 1",
                     err, busy);
         end
         if (stalled) begin
            checks++;
            if (byte_valid !== 1'b1 || dataout !== pd || rs !== prs) begin
               errs++;
               $display("FAIL stall_hold: got v%b %h rs%b want v1 %h rs%b",
                        byte_valid, dataout, rs, pd, prs);
            end
         end
         if (abort >= 0 && pb == abort && byte_valid
             && q.size() > 0 && q[0].pix) begin
            win_req = 1'b0;
            reset = 1'b0;
            #1;
            chk_reset_vals("reset_abort");
            @(negedge clk);
            chk_reset_vals("reset_abort_hold");
            reset = 1'b1;
            @(negedge clk);
            chk_reset_vals("after_abort");
            return;
         end
         if (poke && cyc == 7) begin
            x0 = 9'd5; x1 = 9'd4; y0 = 8'd0; y1 = 8'd0;
            win_req = 1'b1;
         end else begin
            win_req = 1'b0;
         end
         case (mode)
            0: begin
               byte_ready = 1'b1;
               pix_valid = 1'b1;
            end
            1: begin
               br = ~br;
               byte_ready = br;
               pix_valid = (sc >= 5);
            end
            default: begin
               byte_ready = ($urandom_range(0, 3) != 0);
               pix_valid = ($urandom_range(0, 2) != 0);
            end
         endcase
         color = (pi < npix) ? cols[pi] : 16'($urandom);
         if (pix_ready && pix_valid) begin
            pi++;
            sc = 0;
         end else if (pix_ready) begin
            sc++;
         end
         if (byte_valid && byte_ready) begin
            nb++;
            checks++;
            if (q.size() == 0) begin
               errs++;
               $display("FAIL extra_byte: got %h want none", dataout);
            end else begin
               e = q.pop_front();
               if (e.pix) begin
                  tg = {rs, dataout, hpos, vpos};
                  tw = {e.rs, e.b, 9'(e.h), 8'(e.v)};
                  if (tg !== tw) begin
                     errs++;
                     $display("FAIL pix_byte %0d: got %h want %h",
                              nb, tg, tw);
                  end
                  pb++;
               end else begin
                  bg = {8'h00, rs, dataout};
                  bw = {8'h00, e.rs, e.b};
                  if (bg !== bw) begin
                     errs++;
                     $display("FAIL cmd_byte %0d: got %h want %h",
                              nb, bg, bw);
                  end
               end
               if (q.size() == 0) fin = 1;
            end
         end
         stalled = byte_valid && !byte_ready;
         pd = dataout;
         prs = rs;
         @(negedge clk);
      end
      win_req = 1'b0;
      if (!fin) begin
         errs++;
         checks++;
         $display("FAIL timeout: got %0d bytes left want 0", q.size());
         reset = 1'b0;
         @(negedge clk);
         reset = 1'b1;
         @(negedge clk);
         return;
      end
      checks++;
      if ({done, busy, byte_valid} !== 3'b110) begin
         errs++;
         $display("FAIL done_pulse: got %b want 110",
                  {done, busy, byte_valid});
      end
      @(negedge clk);
      checks++;
      if ({done, busy, hpos, vpos} !== {2'b00, 9'(ax1), 8'(ay1)}) begin
         errs++;
         $display("FAIL done_idle: got %b %b %0d %0d want 0 0 %0d %0d",
                  done, busy, hpos, vpos, ax1, ay1);
      end
   endtask

   task automatic test_basic;
      int nb;
      run_window(10, 11, 5, 6, 0, -1, 0, 16'hA5C3, nb);
      checks++;
      if (nb !== 19) begin
         errs++;
         $display("FAIL basic_count: got %0d want 19", nb);
      end
   endtask

   task automatic test_stall;
      int nb;
      run_window(10, 11, 5, 6, 1, -1, 0, -1, nb);
   endtask

   task automatic test_invalid;
      int bad[4][4];
      bad[0] = '{5, 4, 0, 0};
      bad[1] = '{0, 320, 0, 0};
      bad[2] = '{0, 0, 0, 240};
      bad[3] = '{0, 0, 9, 8};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         x0 = 9'(bad[i][0]); x1 = 9'(bad[i][1]);
         y0 = 8'(bad[i][2]); y1 = 8'(bad[i][3]);
         win_req = 1'b1;
         for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            win_req = 1'b0;
            checks++;
            if ({err, byte_valid, busy} !== {(c == 0), 2'b00}) begin
               errs++;
               $display("FAIL invalid %0d cyc %0d: got %b want %b",
                        i, c, {err, byte_valid, busy},
                        {(c == 0), 2'b00});
            end
         end
      end
   endtask

   task automatic test_corner;
      int nb;
      run_window(319, 319, 239, 239, 0, -1, 0, -1, nb);
      checks++;
      if (nb !== 13) begin
         errs++;
         $display("FAIL corner_count: got %0d want 13", nb);
      end
   endtask

   task automatic test_reset_mid;
      int nb;
      run_window(10, 13, 5, 6, 0, 4, 0, -1, nb);
      run_window(10, 11, 5, 6, 2, -1, 0, -1, nb);
   endtask

   task automatic test_busy_req;
      int nb;
      run_window(20, 22, 100, 100, 0, -1, 1, -1, nb);
   endtask

   task automatic test_full_screen;
      int nb;
      run_window(0, 319, 0, 239, 0, 0, 0, -1, nb);
   endtask

   task automatic test_random;
      int nb, ax0, ax1, ay0, ay1;
      for (int i = 0; i < 6; i++) begin
         ax0 = $urandom_range(0, 319);
         ax1 = ax0 + $urandom_range(0, 3);
         if (ax1 > 319) ax1 = 319;
         ay0 = $urandom_range(0, 239);
         ay1 = ay0 + $urandom_range(0, 2);
         if (ay1 > 239) ay1 = 239;
         run_window(ax0, ax1, ay0, ay1, 2, -1, 0, -1, nb);
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_stall;
      test_invalid;
      test_corner;
      test_reset_mid;
      test_busy_req;
      test_full_screen;
      test_random;
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
